// File: rtl/bin_to_bcd_seq_if.sv
// Handshake and result bundle between a binary source and the BCD converter.
// The master drives start/bin; the converter (slave) returns status and the packed BCD result.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;
  logic                  overflow;

  modport master (
    output start, bin,
    input  busy, done, bcd, overflow
  );

  modport slave (
    input  start, bin,
    output busy, done, bcd, overflow
  );
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble binary-to-BCD converter, one input bit per clock.
// The bcd/overflow result register holds the previous answer until a conversion completes.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 27,
  parameter int DIGITS = 8
) (
  input  logic              clk,
  input  logic              rst,
  bin_to_bcd_seq_if.slave   bus
);

  // One guard digit above the visible ones catches values past 10^DIGITS-1.
  localparam int SCR_W = 4 * (DIGITS + 1);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             state_r, state_s;
  logic [BIN_W-1:0]   shift_r, shift_s;
  logic [SCR_W-1:0]   scratch_r, scratch_s;
  logic [SCR_W-1:0]   adj_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [BCD_W-1:0]   bcd_r, bcd_s;
  logic               overflow_r, overflow_s;
  logic               busy_r, done_r;

  // Add 3 to every digit that is 5 or more; digits are independent (no carries).
  function automatic logic [SCR_W-1:0] add3(input logic [SCR_W-1:0] v);
    logic [SCR_W-1:0] r;
    r = v;
    for (int k = 0; k < DIGITS + 1; k++) begin
      if (v[4*k +: 4] >= 4'd5) begin
        r[4*k +: 4] = v[4*k +: 4] + 4'd3;
      end else begin
        r[4*k +: 4] = v[4*k +: 4];
      end
    end
    return r;
  endfunction

  // Next-state and datapath update for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_s    = state_r;
    shift_s    = shift_r;
    scratch_s  = scratch_r;
    cnt_s      = cnt_r;
    bcd_s      = bcd_r;
    overflow_s = overflow_r;
    adj_s      = add3(scratch_r);

    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          shift_s   = bus.bin;
          scratch_s = {SCR_W{1'b0}};
          cnt_s     = CNT_W'(BIN_W);
          state_s   = ST_SHIFT;
        end else begin
          state_s   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        {scratch_s, shift_s} = {adj_s[SCR_W-2:0], shift_r, 1'b0};
        cnt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (scratch_r[SCR_W-1 -: 4] != 4'd0) begin
          overflow_s = 1'b1;
          bcd_s      = {DIGITS{4'h9}};
        end else begin
          overflow_s = 1'b0;
          bcd_s      = scratch_r[BCD_W-1:0];
        end
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= ST_IDLE;
      shift_r    <= {BIN_W{1'b0}};
      scratch_r  <= {SCR_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      bcd_r      <= {BCD_W{1'b0}};
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      scratch_r  <= scratch_s;
      cnt_r      <= cnt_s;
      bcd_r      <= bcd_s;
      overflow_r <= overflow_s;
      busy_r     <= (state_s != ST_IDLE);
      done_r     <= (state_s == ST_DONE);
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.bcd      = bcd_r;
  assign bus.overflow = overflow_r;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed plus random checks of bin_to_bcd_seq against a decimal-arithmetic reference.
module tb_bin_to_bcd_seq;

  localparam int BIN_W  = 27;
  localparam int DIGITS = 8;

  logic clk;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  int   done_count = 0;
  logic prev_done = 1'b0;
  logic [31:0] last_bcd = 32'd0;
  logic [31:0] exp_bcd = 32'd0;
  logic        exp_ovf = 1'b0;

  bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain decimal digit extraction with saturation above 10^8-1.
  function automatic void ref_conv(input int unsigned v, output logic [31:0] b, output logic o);
    int unsigned t;
    b = 32'd0;
    if (v > 32'd99999999) begin
      b = 32'h99999999;
      o = 1'b1;
    end else begin
      o = 1'b0;
      t = v;
      for (int k = 0; k < 8; k++) begin
        b[4*k +: 4] = 4'(t % 10);
        t = t / 10;
      end
    end
  endfunction

  // bcd may only move on the cycle right after a done pulse; done never lasts two cycles.
  always @(negedge clk) begin
    if (rst) begin
      chk("done_single", 64'(bus.done & prev_done), 64'd0);
      if (bus.bcd !== last_bcd) chk("bcd_change_after_done", 64'(prev_done), 64'd1);
    end
    if (bus.done) done_count++;
    prev_done = bus.done;
    last_bcd  = bus.bcd;
  end

  task automatic wait_done(output int at, output int nb);
    at = -1;
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy) nb++;
      if (bus.done) begin
        at = cyc;
        break;
      end
      @(negedge clk);
    end
    chk("done_seen", 64'(at >= 0), 64'd1);
  endtask

  task automatic run_one(input logic [26:0] v);
    int acc, at, nb;
    logic [31:0] eb;
    logic        eo;
    ref_conv(32'(v), eb, eo);
    @(negedge clk);
    bus.bin   = v;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = 27'($urandom);
    acc = cyc;
    wait_done(at, nb);
    chk("latency", 64'(at - acc + 1), 64'd28);
    chk("busy_cycles", 64'(nb), 64'd28);
    chk("bcd_hold", 64'(bus.bcd), 64'(exp_bcd));
    chk("ovf_hold", 64'(bus.overflow), 64'(exp_ovf));
    @(negedge clk);
    chk("bcd", 64'(bus.bcd), 64'(eb));
    chk("ovf", 64'(bus.overflow), 64'(eo));
    chk("busy_after", 64'(bus.busy), 64'd0);
    chk("done_after", 64'(bus.done), 64'd0);
    exp_bcd = eb;
    exp_ovf = eo;
  endtask

  initial begin
    int acc, at1, at2, nb, d0;
    logic [31:0] eb1, eb2;
    logic        eo1, eo2;

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.bin   = 27'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_done", 64'(bus.done), 64'd0);
    chk("rst_bcd", 64'(bus.bcd), 64'd0);
    chk("rst_ovf", 64'(bus.overflow), 64'd0);
    rst = 1'b1;

    run_one(27'd0);
    run_one(27'd12345678);
    run_one(27'd99999999);
    run_one(27'd100000000);
    run_one(27'd134217727);
    run_one(27'd99999998);
    run_one(27'd100000001);

    // Start and bin activity during SHIFT must be ignored.
    ref_conv(32'd5, eb1, eo1);
    @(negedge clk);
    bus.bin   = 27'd5;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    acc = cyc;
    d0  = done_count;
    bus.bin = 27'd7;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.bin   = 27'($urandom);
    end
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(at1, nb);
    chk("ign_latency", 64'(at1 - acc + 1), 64'd28);
    @(negedge clk);
    chk("ign_bcd", 64'(bus.bcd), 64'(eb1));
    exp_bcd = eb1;
    exp_ovf = eo1;
    repeat (40) @(negedge clk);
    chk("ign_single_done", 64'(done_count - d0), 64'd1);
    chk("ign_idle", 64'(bus.busy), 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_one(27'($urandom_range(134217727, 0)));
    end

    // Back-to-back: second start in the first IDLE cycle after DONE.
    ref_conv(32'd42, eb1, eo1);
    ref_conv(32'd9876543, eb2, eo2);
    @(negedge clk);
    bus.bin   = 27'd42;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(at1, nb);
    @(negedge clk);
    chk("b2b_bcd1", 64'(bus.bcd), 64'(eb1));
    bus.bin   = 27'd9876543;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(at2, nb);
    chk("b2b_gap", 64'(at2 - at1), 64'd29);
    @(negedge clk);
    chk("b2b_bcd2", 64'(bus.bcd), 64'(eb2));
    chk("b2b_ovf2", 64'(bus.overflow), 64'(eo2));

    // Reset in the middle of a conversion.
    @(negedge clk);
    bus.bin   = 27'd31415926;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    d0 = done_count;
    repeat (9) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_bcd", 64'(bus.bcd), 64'd0);
    chk("mid_rst_busy", 64'(bus.busy), 64'd0);
    chk("mid_rst_done", 64'(bus.done), 64'd0);
    chk("mid_rst_ovf", 64'(bus.overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_bcd = 32'd0;
    exp_ovf = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_rst_no_done", 64'(done_count - d0), 64'd0);
    chk("mid_rst_bcd_held", 64'(bus.bcd), 64'd0);
    run_one(27'd27);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative double-dabble (shift-and-add-3), one input bit per clock.
- Sits directly upstream of the multiplexed seven-segment display driver. Its registered bcd output feeds the display's packed nibble input, so binary counters and measurements show as decimal digits.
- The output register holds the last valid result while a new conversion runs, so the display never shows partial values.

Parameters:
- BIN_W, 27, width of binary input; 27 bits covers 0..99,999,999.
- DIGITS, 8, number of BCD digits produced; bcd width is 4*DIGITS (32 = display N default).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  conversion request; sampled only in IDLE.
- bin  in  BIN_W  binary value; captured on the accepted start cycle only.
- busy  out  1  high while a conversion is in progress (SHIFT or DONE state).
- done  out  1  single-cycle pulse when bcd/overflow update.
- bcd  out  4*DIGITS  packed BCD result; digit k is bcd[4k+3:4k], digit 0 is least significant.
- overflow  out  1  last converted value exceeded 10^DIGITS-1.

Behaviour:
- Reset (rst==0 at a clock edge): state=IDLE; bcd=0; busy=0; done=0; overflow=0; internal shift/scratch registers and bit counter cleared. Reset mid-conversion aborts the conversion; no done pulse is produced and no partial result is kept.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1: load shift register with bin, clear scratch BCD (DIGITS+1 digits, one guard digit), set counter=BIN_W, go to SHIFT.
- SHIFT (busy=1):
  - Each cycle, every scratch digit >=5 gets +3 (4-bit, no carry between digits).
  - The {scratch, shift register} concatenation is then shifted left by 1; the MSB of bin enters scratch bit 0.
  - Counter decrements; when it reaches 0 after the BIN_W-th shift, go to DONE.
- DONE (busy=1, done=1 for this cycle only):
  - If the guard digit is nonzero, or any lower digit is nonzero beyond capacity: overflow=1 and bcd=all digits 9 (saturate).
  - Otherwise overflow=0 and bcd=lower DIGITS scratch digits.
  - bcd and overflow are registered, so the new values are visible the cycle after done. Go to IDLE.
- Latency: start accepted at edge T → done high during cycle T+BIN_W+1 → new bcd/overflow stable from edge T+BIN_W+2. Default is 28 cycles from accepted start to done.
- start while busy=1 (SHIFT or DONE) is ignored, not queued; bin changes during conversion have no effect.
- Back-to-back: start asserted in the first IDLE cycle after DONE is accepted. Minimum issue interval is BIN_W+2 cycles.
- bcd and overflow change only in DONE or on reset; they hold indefinitely otherwise.
- Overflow check only matters when 2^BIN_W-1 > 10^DIGITS-1; otherwise overflow is constant 0 by construction.
- Add-3 correction is applied before the shift in the same cycle; no combinational path from bin/start to any output.

Test Plan:
- Reset, then bin=0, start pulse → done at 28th cycle after accepting edge, bcd=32'h00000000, overflow=0; busy high exactly 28 cycles.
- bin=12345678 → bcd=32'h12345678, overflow=0; bcd holds previous value (32'h00000000) until the edge after done.
- bin=99999999 → bcd=32'h99999999, overflow=0. Then bin=100000000 → bcd=32'h99999999, overflow=1. Then bin=134217727 → overflow=1.
- Start bin=5; during SHIFT, pulse start with bin=7 and change bin each cycle → single done, bcd=32'h00000005; no second conversion follows.
- Back-to-back: bin=42 start, start re-asserted the first IDLE cycle with bin=9876543 → two done pulses 29 cycles apart, results 32'h00000042 then 32'h09876543.
- Reset mid-conversion: start bin=31415926, drive rst=0 at SHIFT cycle 10 → bcd=0, busy=0, no done. Release, convert 27 → bcd=32'h00000027.
